findmax_ctrl: RTL

//  Control/compare stage for the findMax datapath; drives the enable and data of the max-holding register.

---
 rtl/findmax_pkg.sv | 12 +
 rtl/findmax_ctrl_if.sv | 13 +
 rtl/register.sv | 24 ++
 rtl/findmax_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/findmax_pkg.sv
// rtl/findmax_pkg.sv - shared types and default widths for the findMax control stage
package findmax_pkg;
  localparam int WIDTH_DEF   = 8;
  localparam int COUNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/findmax_ctrl_if.sv
// rtl/findmax_ctrl_if.sv - valid/ready sample stream into the findMax control stage
interface findmax_ctrl_if
  import findmax_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/register.sv
// rtl/register.sv - enabled data register holding the running maximum
module register
  import findmax_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/findmax_ctrl.sv
// rtl/findmax_ctrl.sv - compare/control stage of findMax: scans a run of samples and
// drives the max register's load enable, tracking the first index of the maximum.
module findmax_ctrl
  import findmax_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] len_i,
  findmax_ctrl_if.slave      in_if,
  input  logic [WIDTH-1:0]   reg_q_i,
  output logic [WIDTH-1:0]   reg_d_o,
  output logic               reg_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               empty_o,
  output logic [WIDTH-1:0]   max_out_o,
  output logic [COUNT_W-1:0] max_idx_o
);
  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [COUNT_W-1:0] max_idx_q, max_idx_d;
  logic               empty_q, empty_d;
  logic               in_ready;
  logic               hs;
  logic               new_max;

  assign in_ready = (state_q == FIRST) || (state_q == SCAN);
  assign hs       = in_if.in_valid && in_ready;
  assign new_max  = in_if.in_data > reg_q_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      max_idx_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      max_idx_q <= max_idx_d;
      empty_q   <= empty_d;
    end
  end

  // cnt holds the index of the sample being offered; it stops at len-1 on the last one
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    max_idx_d = max_idx_q;
    empty_d   = empty_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d   = FIRST;
            len_d     = len_i;
            cnt_d     = '0;
            max_idx_d = '0;
            empty_d   = 1'b0;
          end else begin
            state_d = DONE;
            empty_d = 1'b1;
          end
        end
      end
      FIRST: begin
        if (hs) begin
          max_idx_d = '0;
          cnt_d     = COUNT_W'(1);
          state_d   = (len_q == COUNT_W'(1)) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (hs) begin
          if (new_max) begin
            max_idx_d = cnt_q;
          end
          if (cnt_q == len_q - COUNT_W'(1)) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + COUNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    reg_en_o = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      FIRST: begin
        busy_o   = 1'b1;
        reg_en_o = hs;
      end
      SCAN: begin
        busy_o   = 1'b1;
        reg_en_o = hs && new_max;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign in_if.in_ready = in_ready;
  assign reg_d_o        = in_if.in_data;
  assign max_out_o      = reg_q_i;
  assign max_idx_o      = max_idx_q;
  assign empty_o        = empty_q;
endmodule
